// File: rtl/rng_sample_reader.sv
// Receive-side consumer for the 12-bit RNG stream: show-ahead FIFO,
// valid/ready read port, saturating sample counter and 16-bit MISR.
module rng_sample_reader #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] x_in,
    input  logic              sample_en,
    input  logic              clr,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic [CNT_W-1:0]  sample_cnt,
    output logic [15:0]       signature
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       sig_q, sig_d;

    logic push, pop, full, wr_en, fb;

    assign full  = (level_q == ADDR_W'(0) + (ADDR_W+1)'(DEPTH));
    assign push  = sample_en & ~clr;
    assign pop   = rd_valid & rd_ready & ~clr;
    // When full, a write is only allowed if the head is leaving this edge.
    assign wr_en = push & (~full | pop);
    assign fb    = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];

    assign rd_valid   = (level_q != '0);
    assign rd_data    = rd_valid ? mem[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign sample_cnt = cnt_q;
    assign signature  = sig_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        sig_d    = sig_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !wr_en) begin
            level_d = level_q - 1'b1;
        end
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
            sig_d = {sig_q[14:0], fb} ^ {{(16-DATA_W){1'b0}}, x_in};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sig_q    <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            sig_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            sig_q    <= sig_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= x_in;
        end
    end

endmodule

// File: tb/tb_rng_sample_reader.sv
// Scoreboard bench for rng_sample_reader: directed pushes queue expected
// read data; a negedge monitor checks every accepted read in order.
module tb_rng_sample_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] x_in = '0;
    logic        sample_en = 1'b0;
    logic        clr = 1'b0;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic [19:0] sample_cnt;
    logic [15:0] signature;

    int tests = 0;
    int fails = 0;
    logic [11:0] exp_q[$];

    rng_sample_reader dut (
        .clk       (clk),
        .reset     (reset),
        .x_in      (x_in),
        .sample_en (sample_en),
        .clr       (clr),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .sample_cnt(sample_cnt),
        .signature (signature)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one read per cycle where the handshake completes.
    always @(negedge clk) begin
        if (reset && rd_valid && rd_ready && !clr) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rd_unexpected: got %h expected none", rd_data);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if (rd_data !== e) begin
                    fails++;
                    $display("FAIL rd_data: got %h expected %h", rd_data, e);
                end
            end
        end
    end

    task automatic push_q(input logic [11:0] v);
        x_in = v;
        sample_en = 1'b1;
        exp_q.push_back(v);
        step();
        sample_en = 1'b0;
    endtask

    task automatic drain(input int n);
        rd_ready = 1'b1;
        repeat (n) step();
        rd_ready = 1'b0;
    endtask

    task automatic clear();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_data", 32'(rd_data), 0);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_cnt", 32'(sample_cnt), 0);
        chk("rst_sig", 32'(signature), 0);
        reset = 1'b1;
        step();

        // MISR golden values
        push_q(12'hABC);
        chk("sig1", 32'(signature), 32'h0ABC);
        push_q(12'h123);
        chk("sig2", 32'(signature), 32'h145A);
        chk("cnt2", 32'(sample_cnt), 2);
        chk("lvl2", 32'(fifo_level), 2);
        chk("head", 32'(rd_data), 32'hABC);
        drain(2);
        chk("lvl_drain1", 32'(fifo_level), 0);

        // fill, overflow, drain
        clear();
        for (int i = 1; i <= 16; i++) push_q(12'(i));
        chk("full_lvl", 32'(fifo_level), 16);
        chk("full_ovf", 32'(overflow), 0);
        x_in = 12'h011;
        sample_en = 1'b1;
        step();
        sample_en = 1'b0;
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_lvl", 32'(fifo_level), 16);
        chk("ovf_cnt", 32'(sample_cnt), 17);
        chk("ovf_head", 32'(rd_data), 32'h001);
        drain(16);
        chk("drain_valid", 32'(rd_valid), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // full with simultaneous push and pop
        clear();
        chk("clr_ovf", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) push_q(12'(12'h020 + i));
        x_in = 12'h7FF;
        sample_en = 1'b1;
        rd_ready = 1'b1;
        exp_q.push_back(12'h7FF);
        step();
        sample_en = 1'b0;
        rd_ready = 1'b0;
        chk("pp_lvl", 32'(fifo_level), 16);
        chk("pp_ovf", 32'(overflow), 0);
        drain(16);
        chk("pp_empty", 32'(rd_valid), 0);

        // streaming: level holds at 1, pointers wrap
        clear();
        rd_ready = 1'b1;
        sample_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            x_in = 12'(12'h100 + i);
            exp_q.push_back(x_in);
            step();
            if (i == 0 || i == 20 || i == 39) begin
                chk("stream_valid", 32'(rd_valid), 1);
                chk("stream_lvl", 32'(fifo_level), 1);
                chk("stream_data", 32'(rd_data), 32'(12'h100 + i));
            end
        end
        sample_en = 1'b0;
        step();
        rd_ready = 1'b0;
        chk("stream_end", 32'(rd_valid), 0);

        // clr mid-stream
        for (int i = 0; i < 5; i++) push_q(12'(12'h200 + i));
        chk("pre_clr_lvl", 32'(fifo_level), 5);
        x_in = 12'h555;
        sample_en = 1'b1;
        rd_ready = 1'b1;
        clr = 1'b1;
        exp_q.delete();
        step();
        clr = 1'b0;
        sample_en = 1'b0;
        rd_ready = 1'b0;
        chk("clr_lvl", 32'(fifo_level), 0);
        chk("clr_valid", 32'(rd_valid), 0);
        chk("clr_cnt", 32'(sample_cnt), 0);
        chk("clr_sig", 32'(signature), 0);
        chk("clr_ovf2", 32'(overflow), 0);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) push_q(12'(12'h300 + i));
        chk("pre_rst_lvl", 32'(fifo_level), 3);
        #2;
        reset = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_valid", 32'(rd_valid), 0);
        chk("arst_lvl", 32'(fifo_level), 0);
        chk("arst_sig", 32'(signature), 0);
        #2;
        reset = 1'b1;
        push_q(12'hABC);
        chk("post_sig", 32'(signature), 32'h0ABC);
        chk("post_lvl", 32'(fifo_level), 1);
        chk("post_cnt", 32'(sample_cnt), 1);
        drain(1);

        chk("sb_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
